// File: rtl/ins_fetcher.sv
// Instruction fetch front end: fetch PC, direct-mapped I-cache, registered window to decode.
// Latency: one cycle from target lookup to presented window on a hit; miss refill then one re-lookup cycle.
// Backpressure: decoder stall holds the presented window; global rdy_in low freezes every register.
module ins_fetcher #(
    parameter int IDX_BIT  = 4,
    parameter int LINE_BIT = 4
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       rdy_in,
    input  logic                       rob_clear,
    input  logic [31:0]                rob_set_pc,
    output logic                       inst_input,
    output logic [31:0]                inst,
    output logic [31:0]                inst_addr,
    input  logic                       is_stall,
    input  logic [31:0]                next_PC,
    output logic                       mem_req,
    output logic [31:0]                mem_addr,
    input  logic                       mem_done,
    input  logic [(8<<LINE_BIT)-1:0]   mem_data
);

    localparam int LINES   = 1 << IDX_BIT;
    localparam int TAG_BIT = 32 - IDX_BIT - LINE_BIT;
    localparam int LINE_W  = 8 << LINE_BIT;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    // Architectural fetch PC and the next values of every register.
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        inst_input_d;
    logic [31:0] inst_d;
    logic [31:0] inst_addr_d;
    logic        mem_req_d;
    logic [31:0] mem_addr_d;
    logic        fill;

    // Cache storage; only the valid bits need a reset value.
    logic [LINES-1:0]   valid_q;
    logic [TAG_BIT-1:0] tag_mem  [LINES];
    logic [LINE_W-1:0]  data_mem [LINES];

    // Lookup datapath signals.
    logic [31:0]         target;
    logic [31:0]         target_b;
    logic [IDX_BIT-1:0]  idx_a;
    logic [IDX_BIT-1:0]  idx_b;
    logic [TAG_BIT-1:0]  tag_a;
    logic [TAG_BIT-1:0]  tag_b;
    logic [31:0]         line_a;
    logic [31:0]         line_b;
    logic [31:0]         miss_line;
    logic                straddle;
    logic                hit_a;
    logic                hit_b;
    logic [LINE_W-1:0]   data_a;
    logic [LINE_W-1:0]   data_b;
    logic [LINE_BIT-1:0] off_h0;
    logic [LINE_BIT-1:0] off_h1;
    logic [LINE_BIT+2:0] bit_h0;
    logic [LINE_BIT+2:0] bit_h1;
    logic [15:0]         hw_first;
    logic [15:0]         hw_second;
    logic [31:0]         window;

    // Refill destination comes straight from the held request address.
    logic [IDX_BIT-1:0]  fill_idx;
    logic [TAG_BIT-1:0]  fill_tag;

    assign fill_idx = mem_addr[LINE_BIT +: IDX_BIT];
    assign fill_tag = mem_addr[LINE_BIT+IDX_BIT +: TAG_BIT];

    // With nothing presented the fetch PC is retried; otherwise the decoder's successor is the target.
    assign target   = inst_input ? next_PC : pc_q;
    assign target_b = target + 32'd2;

    assign idx_a = target[LINE_BIT +: IDX_BIT];
    assign tag_a = target[LINE_BIT+IDX_BIT +: TAG_BIT];
    assign idx_b = target_b[LINE_BIT +: IDX_BIT];
    assign tag_b = target_b[LINE_BIT+IDX_BIT +: TAG_BIT];

    assign line_a = {target[31:LINE_BIT], {LINE_BIT{1'b0}}};
    assign line_b = {target_b[31:LINE_BIT], {LINE_BIT{1'b0}}};

    // A halfword-aligned PC in the last halfword of a line pulls its second half from the next line.
    assign straddle = &target[LINE_BIT-1:1];

    assign hit_a = valid_q[idx_a] && (tag_mem[idx_a] == tag_a);
    assign hit_b = !straddle || (valid_q[idx_b] && (tag_mem[idx_b] == tag_b));

    // The first needed line that is absent is the one refilled first.
    assign miss_line = hit_a ? line_b : line_a;

    assign data_a = data_mem[idx_a];
    assign data_b = data_mem[idx_b];

    // Both halfwords of the window; the second offset wraps to zero exactly on a straddle.
    assign off_h0 = {target[LINE_BIT-1:1], 1'b0};
    assign off_h1 = off_h0 + LINE_BIT'(2);
    assign bit_h0 = {off_h0, 3'b000};
    assign bit_h1 = {off_h1, 3'b000};

    assign hw_first  = data_a[bit_h0 +: 16];
    assign hw_second = straddle ? data_b[bit_h1 +: 16] : data_a[bit_h1 +: 16];

    // Word-aligned: little-endian word. Halfword-aligned: first halfword goes to the upper half.
    assign window = target[1] ? {hw_first, hw_second} : {hw_second, hw_first};

    // Next-state and next-output logic; redirect outranks everything, refills are never abandoned.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_input_d = inst_input;
        inst_d       = inst;
        inst_addr_d  = inst_addr;
        mem_req_d    = mem_req;
        mem_addr_d   = mem_addr;
        fill         = 1'b0;
        case (state_q)
            IDLE: begin
                if (rob_clear) begin
                    pc_d         = rob_set_pc;
                    inst_input_d = 1'b0;
                end else if (!(inst_input && is_stall)) begin
                    pc_d = target;
                    if (hit_a && hit_b) begin
                        inst_d       = window;
                        inst_addr_d  = target;
                        inst_input_d = 1'b1;
                    end else begin
                        inst_input_d = 1'b0;
                        mem_req_d    = 1'b1;
                        mem_addr_d   = miss_line;
                        state_d      = MISS;
                    end
                end
            end
            MISS: begin
                if (mem_done) begin
                    fill      = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
                if (rob_clear) begin
                    pc_d         = rob_set_pc;
                    inst_input_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else if (rdy_in) begin
            state_q <= state_d;
        end
    end

    // Fetch PC, decoder-facing window and refill request registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pc_q       <= 32'd0;
            inst_input <= 1'b0;
            inst       <= 32'd0;
            inst_addr  <= 32'd0;
            mem_req    <= 1'b0;
            mem_addr   <= 32'd0;
        end else if (rdy_in) begin
            pc_q       <= pc_d;
            inst_input <= inst_input_d;
            inst       <= inst_d;
            inst_addr  <= inst_addr_d;
            mem_req    <= mem_req_d;
            mem_addr   <= mem_addr_d;
        end
    end

    // Line valid bits; a refill marks its line valid, overwriting any conflicting line.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_q <= '0;
        end else if (rdy_in && fill) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    // Tag and data arrays, written only by a completed refill.
    always_ff @(posedge clk_in) begin
        if (rdy_in && fill) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= mem_data;
        end
    end

endmodule

// File: tb/tb_ins_fetcher.sv
// Bench for ins_fetcher: directed fetch scenarios followed by randomized traffic.
// A flat byte memory plus a line-address cache map predicts every cycle's outputs.
// The bench acts as both the memory controller and the decoder.
module tb_ins_fetcher;

    logic         clk_in;
    logic         rst_in;
    logic         rdy_in;
    logic         rob_clear;
    logic [31:0]  rob_set_pc;
    logic         inst_input;
    logic [31:0]  inst;
    logic [31:0]  inst_addr;
    logic         is_stall;
    logic [31:0]  next_PC;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_done;
    logic [127:0] mem_data;

    ins_fetcher #(.IDX_BIT(4), .LINE_BIT(4)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .rdy_in     (rdy_in),
        .rob_clear  (rob_clear),
        .rob_set_pc (rob_set_pc),
        .inst_input (inst_input),
        .inst       (inst),
        .inst_addr  (inst_addr),
        .is_stall   (is_stall),
        .next_PC    (next_PC),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_done   (mem_done),
        .mem_data   (mem_data)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:4095];

    // Reference model state: what the fetcher must be showing.
    logic [31:0] m_pc;
    logic        m_vld;
    logic [31:0] m_inst;
    logic [31:0] m_iaddr;
    logic        m_miss;
    logic [31:0] m_maddr;
    logic [31:0] cache [int unsigned];  // line slot -> line address held there

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] line_data(input logic [31:0] la);
        logic [127:0] d;
        for (int b = 0; b < 16; b++) d[b*8 +: 8] = mem[int'(la) + b];
        return d;
    endfunction

    function automatic int unsigned slot_of(input logic [31:0] la);
        return (la / 16) % 16;
    endfunction

    function automatic bit cached(input logic [31:0] la);
        return cache.exists(slot_of(la)) && (cache[slot_of(la)] == la);
    endfunction

    // Window straight from the byte memory: word, or halfword at t then halfword at t+2.
    function automatic logic [31:0] win(input logic [31:0] t);
        int a;
        a = int'(t);
        if (t % 4 == 0) return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
        return {mem[a+1], mem[a], mem[a+3], mem[a+2]};
    endfunction

    task automatic model_reset();
        m_pc = 0; m_vld = 0; m_inst = 0; m_iaddr = 0; m_miss = 0; m_maddr = 0;
        cache.delete();
    endtask

    // One clock edge of the reference behaviour, using the inputs driven for that edge.
    task automatic model_step();
        logic [31:0] t, la, lb;
        if (!rdy_in) return;
        if (m_miss) begin
            if (mem_done) begin
                cache[slot_of(m_maddr)] = m_maddr;
                m_miss = 0;
            end
            if (rob_clear) begin
                m_pc = rob_set_pc;
                m_vld = 0;
            end
            return;
        end
        if (rob_clear) begin
            m_pc = rob_set_pc;
            m_vld = 0;
            return;
        end
        if (m_vld && is_stall) return;
        t = m_vld ? next_PC : m_pc;
        m_pc = t;
        la = t - (t % 16);
        lb = la + 16;
        if (!cached(la)) begin
            m_vld = 0; m_miss = 1; m_maddr = la;
        end else if ((t % 16 == 14) && !cached(lb)) begin
            m_vld = 0; m_miss = 1; m_maddr = lb;
        end else begin
            m_vld = 1; m_inst = win(t); m_iaddr = t;
        end
    endtask

    // The single per-cycle comparison against the model.
    task automatic compare();
        chk("inst_input", {31'd0, inst_input}, {31'd0, m_vld});
        chk("mem_req", {31'd0, mem_req}, {31'd0, m_miss});
        if (m_vld) begin
            chk("inst", inst, m_inst);
            chk("inst_addr", inst_addr, m_iaddr);
        end
        if (m_miss) chk("mem_addr", mem_addr, m_maddr);
    endtask

    task automatic tick();
        @(posedge clk_in);
        model_step();
        #1;
        compare();
    endtask

    task automatic give_fill();
        mem_done = 1'b1;
        mem_data = line_data(m_maddr);
        tick();
        mem_done = 1'b0;
    endtask

    function automatic logic [31:0] rand_pc();
        return $urandom_range(0, 32'h1FF) * 2;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h13; mem[1] = 8'h00; mem[2] = 8'h00; mem[3] = 8'h00;
        mem[14] = 8'h13; mem[15] = 8'h05; mem[16] = 8'h00; mem[17] = 8'h00;

        rst_in = 1'b1; rdy_in = 1'b1; rob_clear = 1'b0; rob_set_pc = 0;
        is_stall = 1'b0; next_PC = 0; mem_done = 1'b0; mem_data = '0;
        model_reset();
        @(posedge clk_in); @(posedge clk_in); #1;
        chk("reset inst_input", {31'd0, inst_input}, 32'd0);
        chk("reset inst", inst, 32'd0);
        chk("reset inst_addr", inst_addr, 32'd0);
        chk("reset mem_req", {31'd0, mem_req}, 32'd0);
        chk("reset mem_addr", mem_addr, 32'd0);
        rst_in = 1'b0;

        // Cold start
        tick();
        chk("cold mem_req", {31'd0, mem_req}, 32'd1);
        chk("cold mem_addr", mem_addr, 32'h0);
        tick(); tick();
        give_fill();
        chk("E0 inst_input", {31'd0, inst_input}, 32'd0);
        chk("E0 mem_req", {31'd0, mem_req}, 32'd0);
        tick();
        chk("cold inst_input", {31'd0, inst_input}, 32'd1);
        chk("cold inst", inst, 32'h00000013);
        chk("cold inst_addr", inst_addr, 32'h0);
        chk("model cold inst", m_inst, 32'h00000013);

        // Sequential hits with a stall at 0x4
        next_PC = 32'h4; tick();
        chk("seq 4", inst_addr, 32'h4);
        is_stall = 1'b1; next_PC = 32'h8;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall inst_addr", inst_addr, 32'h4);
            chk("stall inst_input", {31'd0, inst_input}, 32'd1);
            chk("stall mem_req", {31'd0, mem_req}, 32'd0);
        end
        is_stall = 1'b0; tick();
        chk("release 8", inst_addr, 32'h8);
        next_PC = 32'hC; tick();
        chk("seq C", inst_addr, 32'hC);

        // Straddling compressed fetch at 0xE with line 0x10 cold
        next_PC = 32'hE; tick();
        chk("straddle mem_req", {31'd0, mem_req}, 32'd1);
        chk("straddle mem_addr", mem_addr, 32'h10);
        give_fill(); tick();
        chk("straddle inst", inst, 32'h05130000);
        chk("straddle inst_addr", inst_addr, 32'hE);
        chk("model straddle inst", m_inst, 32'h05130000);

        // Flush while a refill is outstanding
        next_PC = 32'h40; tick();
        chk("flush miss addr", mem_addr, 32'h40);
        rob_clear = 1'b1; rob_set_pc = 32'h100; tick(); rob_clear = 1'b0;
        chk("flush held req", {31'd0, mem_req}, 32'd1);
        chk("flush held addr", mem_addr, 32'h40);
        tick();
        give_fill();
        tick();
        chk("redirect miss addr", mem_addr, 32'h100);
        give_fill(); tick();
        chk("redirect inst_addr", inst_addr, 32'h100);

        // Conflict back to 0x000, then line 0x40 must still be resident
        next_PC = 32'h0; tick();
        chk("conflict miss addr", mem_addr, 32'h0);
        give_fill(); tick();
        chk("conflict inst", inst, 32'h00000013);
        next_PC = 32'h40; tick();
        chk("0x40 hit inst_addr", inst_addr, 32'h40);
        chk("0x40 hit mem_req", {31'd0, mem_req}, 32'd0);

        // Global ready low freezes everything, even a stray mem_done
        rdy_in = 1'b0; next_PC = 32'h44; mem_done = 1'b1;
        tick(); tick();
        chk("frozen inst_addr", inst_addr, 32'h40);
        rdy_in = 1'b1; mem_done = 1'b0;
        tick();
        chk("thaw inst_addr", inst_addr, 32'h44);

        // Reset in the middle of a miss drops the request
        next_PC = 32'h200; tick();
        chk("pre-reset mem_req", {31'd0, mem_req}, 32'd1);
        #3 rst_in = 1'b1;
        #1;
        chk("mid-miss reset mem_req", {31'd0, mem_req}, 32'd0);
        chk("mid-miss reset inst_input", {31'd0, inst_input}, 32'd0);
        model_reset();
        @(posedge clk_in); #1;
        rst_in = 1'b0;

        // Randomized traffic
        lat = -1;
        for (int c = 0; c < 3000; c++) begin
            rdy_in     = ($urandom_range(0, 19) != 0);
            rob_clear  = ($urandom_range(0, 39) == 0);
            rob_set_pc = rand_pc();
            is_stall   = ($urandom_range(0, 4) == 0);
            if (m_vld) begin
                if ($urandom_range(0, 9) == 0) next_PC = rand_pc();
                else next_PC = m_iaddr + (($urandom_range(0, 1) == 1) ? 32'd2 : 32'd4);
                if (next_PC > 32'h3FE) next_PC = rand_pc();
            end else begin
                next_PC = rand_pc();
            end
            mem_done = 1'b0;
            mem_data = {$urandom, $urandom, $urandom, $urandom};
            if (m_miss) begin
                if (lat < 0) lat = $urandom_range(0, 4);
                if (lat == 0) begin
                    mem_done = 1'b1;
                    mem_data = line_data(m_maddr);
                    lat = -1;
                end else begin
                    lat--;
                end
            end else if ($urandom_range(0, 19) == 0) begin
                mem_done = 1'b1;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
